// File: rtl/bus_pkg.sv
// Definitions shared by every block that drives the computer bus
// (the output register and the input port).
package bus_pkg;
  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] BUS_Z = {WORD_W{1'bz}};
endpackage

// File: rtl/input_port_if.sv
// External-device handshake into the input port. The device is the master;
// the port is the slave.
interface input_port_if
  import bus_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic [WIDTH-1:0] ext_data;
  logic             ext_valid;
  logic             ext_ready;

  modport master (output ext_data, output ext_valid, input ext_ready);
  modport slave  (input ext_data, input ext_valid, output ext_ready);
endinterface

// File: rtl/input_fifo.sv
// Byte store for the input port: DEPTH-entry circular buffer with wrap-around
// pointers and an occupancy count. Storage itself is never reset.
module input_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap simply by overflowing.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/input_port.sv
// Input port: buffers bytes from an external device and, when the control unit
// raises ei, places the oldest byte on the shared tri-state bus and pops it.
module input_port
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input_port_if.slave      ext,
  input  logic             ei,
  output wire  [WIDTH-1:0] out_bus,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             underflow
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] bus_data;
  logic             push;
  logic             pop;
  logic             underflow_q, underflow_d;

  assign ext.ext_ready = !full && !clear;
  assign push          = ext.ext_valid && ext.ext_ready;
  assign pop           = ei && !empty;

  input_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (ext.ext_data),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // No bypass: a byte pushed into an empty buffer is not visible until next cycle.
  always_comb begin
    bus_data    = head;
    underflow_d = underflow_q;
    if (empty) bus_data = '0;
    if (ei && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) underflow_q <= 1'b0;
    else       underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;

  assign out_bus = ei ? bus_data : {WIDTH{BUS_Z[0]}};

endmodule
